stopwatch_ctrl: RTL and testbench

Front-end controller for the stopwatch display chain. It synchronizes and debounces the two raw push-buttons and runs an IDLE/RUN/PAUSE state machine. It divides the system clock into a single-cycle `tick` that drives `count_enable_in` of the least-significant `counter_flop` stage. It also emits a one-cycle `clear` pulse that zeroes the whole digit chain.

---
 rtl/stopwatch_ctrl.sv | 121 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: synchronizes and debounces both push-buttons, runs the
// IDLE/RUN/PAUSE controller and divides the clock into the digit-chain tick.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       tick,
    output logic       clear,
    output logic       running,
    output logic [1:0] state
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] DB_DONE  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        UNUSED = 2'd3
    } state_t;

    // Bit 0 carries start/stop, bit 1 carries clear, through every button stage.
    logic [1:0]       btn_raw;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       level;
    logic [1:0]       level_q;
    logic [1:0]       press;
    logic [CNT_W-1:0] db_cnt [2];
    state_t           state_q;
    logic [PRE_W-1:0] presc;

    assign btn_raw = {btn_clear, btn_start_stop};
    assign state   = state_q;

    // NOTE: non-blocking assignments make every flop below update from the
    // pre-edge values, which is what turns sync_a -> sync_b into a real pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= '0;
            sync_b  <= '0;
            level   <= '0;
            level_q <= '0;
            press   <= '0;
            // NOTE: the debounce counters are ordinary flops, not RAM, so they
            // are cleared with the rest of the state.
            for (int b = 0; b < 2; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            sync_a  <= btn_raw;
            sync_b  <= sync_a;
            level_q <= level;
            press   <= level & ~level_q;
            for (int b = 0; b < 2; b++) begin
                if (db_cnt[b] == DB_DONE) begin
                    level[b]  <= ~level[b];
                    db_cnt[b] <= '0;
                end else if (sync_b[b] != level[b]) begin
                    db_cnt[b] <= db_cnt[b] + CNT_W'(1);
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            clear   <= 1'b0;
            running <= 1'b0;
        end else begin
            tick  <= 1'b0;
            clear <= 1'b0;

            // The prescaler also advances on the edge that leaves RUN.
            if (state_q == RUN) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + PRE_W'(1);
                end
            end

            case (state_q)
                IDLE, PAUSE: begin
                    if (press[0]) begin
                        state_q <= RUN;
                        running <= 1'b1;
                    end else if (press[1]) begin
                        state_q <= IDLE;
                        clear   <= 1'b1;
                        presc   <= '0;
                    end
                end
                RUN: begin
                    // A clear press here is dropped; the user must pause first.
                    if (press[0]) begin
                        state_q <= PAUSE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    running <= 1'b0;
                    presc   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl: directed feature tasks plus a randomized
// press sequence, all judged against a press-schedule + cycle-count model.
module tb_stopwatch_ctrl;
    localparam int TD  = 10;
    localparam int DB  = 4;
    localparam int LAT = DB + 4;  // edges from first high sample to state update

    logic       clk;
    logic       rst;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       tick;
    logic       clear;
    logic       running;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: presses are scheduled events, the controller is plain arithmetic.
    logic [1:0] m_state;
    int         m_presc;
    bit         m_tick;
    bit         m_clear;
    int         ss_q[$];
    int         clr_q[$];
    int         hold_ss;
    int         hold_clr;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .tick          (tick),
        .clear         (clear),
        .running       (running),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance model and DUT by one rising edge; outputs are stable 1 time unit later.
    task automatic cycle();
        int  e;
        bit  ss;
        bit  cl;
        e  = cyc + 1;
        ss = 1'b0;
        cl = 1'b0;
        if (rst) begin
            m_state = 2'd0;
            m_presc = 0;
            m_tick  = 1'b0;
            m_clear = 1'b0;
            ss_q.delete();
            clr_q.delete();
        end else begin
            if (ss_q.size() > 0 && ss_q[0] == e) begin
                ss = 1'b1;
                void'(ss_q.pop_front());
            end
            if (clr_q.size() > 0 && clr_q[0] == e) begin
                cl = 1'b1;
                void'(clr_q.pop_front());
            end
            m_tick  = (m_state == 2'd1) && (m_presc == TD - 1);
            m_clear = 1'b0;
            if (m_state == 2'd1) m_presc = (m_presc + 1) % TD;
            if (ss) begin
                m_state = (m_state == 2'd1) ? 2'd2 : 2'd1;
            end else if (cl && m_state != 2'd1) begin
                m_state = 2'd0;
                m_clear = 1'b1;
                m_presc = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hold_ss > 0) begin
            hold_ss--;
            if (hold_ss == 0) btn_start_stop = 1'b0;
        end
        if (hold_clr > 0) begin
            hold_clr--;
            if (hold_clr == 0) btn_clear = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    // Raise a button for len edges; long holds (>= DB+2) schedule one press.
    task automatic press(input bit which, input int len);
        if (!which) begin
            btn_start_stop = 1'b1;
            hold_ss        = len;
            if (len >= DB + 2) ss_q.push_back(cyc + 1 + LAT);
        end else begin
            btn_clear = 1'b1;
            hold_clr  = len;
            if (len >= DB + 2) clr_q.push_back(cyc + 1 + LAT);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_start_stop = 1'b1;
        btn_clear = 1'b1;
        cycles(3);
        rst = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if ({tick, clear, running} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs got tick/clear/running=%b exp=000", {tick, clear, running});
        end
        cycles(12);
        checks++;
        if ({state, running} !== 3'b000) begin
            failures++; $display("FAIL reset_idle_after got state=%0d running=%b exp 0/0", state, running);
        end
    endtask

    task automatic test_start_tick();
        int e;
        int ticks;
        int last;
        int wide;
        bit prev;
        press(0, 20);
        cycles(LAT);
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL start_early got=%0d exp=0", state); end
        cycle();
        checks++;
        if ({state, running} !== 3'b011) begin
            failures++; $display("FAIL start_edge got state=%0d running=%b exp 1/1", state, running);
        end
        e = cyc; ticks = 0; last = -1; wide = 0; prev = 1'b0;
        repeat (50) begin
            cycle();
            if (tick === 1'b1) begin
                if (prev) wide++;
                if (last < 0) begin
                    checks++;
                    if (cyc != e + TD) begin failures++; $display("FAIL first_tick got=%0d exp=%0d", cyc - e, TD); end
                end else begin
                    checks++;
                    if (cyc - last != TD) begin failures++; $display("FAIL tick_period got=%0d exp=%0d", cyc - last, TD); end
                end
                last = cyc;
                ticks++;
            end
            prev = (tick === 1'b1);
        end
        checks++;
        if (ticks != 5) begin failures++; $display("FAIL tick_count got=%0d exp=5", ticks); end
        checks++;
        if (wide != 0) begin failures++; $display("FAIL tick_width got=%0d wide pulses exp=0", wide); end
    endtask

    task automatic test_pause_resume();
        int ticks;
        int r;
        int first;
        for (int i = 0; i < 3 * TD && m_presc != 8; i++) cycle();
        if (m_presc != 8) begin failures++; $display("FAIL pause_align got=%0d exp=8", m_presc); end
        press(0, 12);
        cycles(LAT + 1);
        checks++;
        if ({state, running} !== 3'b100) begin
            failures++; $display("FAIL pause_edge got state=%0d running=%b exp 2/0", state, running);
        end
        ticks = 0;
        repeat (100) begin
            cycle();
            if (tick !== 1'b0) ticks++;
        end
        checks++;
        if (ticks != 0) begin failures++; $display("FAIL pause_ticks got=%0d exp=0", ticks); end
        press(0, 12);
        r = cyc + LAT + 1;
        cycles(LAT + 1);
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL resume_edge got=%0d exp=1", state); end
        first = -1;
        repeat (6) begin
            cycle();
            if (tick === 1'b1 && first < 0) first = cyc;
        end
        checks++;
        if (first != r + 3) begin failures++; $display("FAIL resume_tick got=%0d exp=%0d", first - r, 3); end
        cycles(10);
    endtask

    task automatic test_clear_rules();
        int seen;
        press(1, 12);
        cycles(LAT + 1);
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL clear_in_run_state got=%0d exp=1", state); end
        seen = 0;
        repeat (12) begin
            cycle();
            if (clear !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL clear_in_run_pulse got=%0d exp=0", seen); end

        press(0, 12);
        cycles(LAT + 1 + 12);
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL clear_pause_setup got=%0d exp=2", state); end
        press(1, 12);
        cycles(LAT + 1);
        checks++;
        if ({state, clear} !== 3'b001) begin
            failures++; $display("FAIL clear_in_pause got state=%0d clear=%b exp 0/1", state, clear);
        end
        cycle();
        checks++;
        if (clear !== 1'b0) begin failures++; $display("FAIL clear_width got=%b exp=0", clear); end
        cycles(12);

        press(0, 12);
        cycles(LAT + 1 + 12);
        press(0, 12);
        cycles(LAT + 1 + 12);
        press(0, 12);
        press(1, 12);
        cycles(LAT + 1);
        checks++;
        if ({state, clear} !== 3'b010) begin
            failures++; $display("FAIL both_press got state=%0d clear=%b exp 1/0", state, clear);
        end
        cycle();
        checks++;
        if (clear !== 1'b0) begin failures++; $display("FAIL both_press_clear got=%b exp=0", clear); end
        cycles(12);

        press(0, 12);
        cycles(LAT + 1 + 12);
        press(1, 12);
        cycles(LAT + 1 + 12);
    endtask

    task automatic test_bounce();
        int trans;
        logic [1:0] prev;
        trans = 0;
        prev  = state;
        repeat (10) begin
            press(0, 2);
            repeat (4) begin
                cycle();
                if (state !== prev) trans++;
                prev = state;
            end
        end
        press(0, 20);
        repeat (30) begin
            cycle();
            if (state !== prev) trans++;
            prev = state;
        end
        checks++;
        if (trans != 1) begin failures++; $display("FAIL bounce_transitions got=%0d exp=1", trans); end
        checks++;
        if (state !== m_state) begin failures++; $display("FAIL bounce_state got=%0d exp=%0d", state, m_state); end
    endtask

    task automatic test_reset_mid();
        int bad;
        int e;
        int first;
        for (int i = 0; i < 3 * TD && m_presc != 3; i++) cycle();
        if (m_presc != 3) begin failures++; $display("FAIL midreset_align got=%0d exp=3", m_presc); end
        press(0, 20);
        cycles(2);
        rst = 1'b1;
        btn_start_stop = 1'b0;
        hold_ss = 0;
        cycle();
        rst = 1'b0;
        checks++;
        if ({state, tick, clear, running} !== 5'b00000) begin
            failures++; $display("FAIL midreset_outputs got state=%0d tick=%b clear=%b running=%b exp all 0", state, tick, clear, running);
        end
        bad = 0;
        repeat (15) begin
            cycle();
            if (tick !== 1'b0 || state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midreset_quiet got=%0d exp=0", bad); end
        press(0, 20);
        e = cyc + LAT + 1;
        cycles(LAT + 1);
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL midreset_restart got=%0d exp=1", state); end
        first = -1;
        repeat (TD + 3) begin
            cycle();
            if (tick === 1'b1 && first < 0) first = cyc;
        end
        checks++;
        if (first != e + TD) begin failures++; $display("FAIL midreset_first_tick got=%0d exp=%0d", first - e, TD); end
        cycles(15);
    endtask

    task automatic test_random();
        int r;
        int len_a;
        int len_b;
        int n;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        for (int it = 0; it < 60; it++) begin
            r     = $urandom_range(0, 9);
            len_a = $urandom_range(DB + 2, DB + 14);
            len_b = $urandom_range(DB + 2, DB + 14);
            if (r < 5) begin
                press(0, len_a);
            end else if (r < 8) begin
                press(1, len_a);
            end else if (r == 8) begin
                press(0, len_a);
                press(1, len_b);
            end else begin
                len_a = $urandom_range(1, DB - 1);
                press($urandom_range(0, 1) == 1, len_a);
            end
            n = ((len_a > len_b) ? len_a : len_b) + 12 + $urandom_range(0, 25);
            repeat (n) begin
                cycle();
                checks++;
                if ({running, state, tick, clear} !== {m_state == 2'd1, m_state, m_tick, m_clear}) begin
                    failures++;
                    $display("FAIL random cyc=%0d got run=%b st=%0d tick=%b clr=%b exp run=%b st=%0d tick=%b clr=%b",
                             cyc, running, state, tick, clear, m_state == 2'd1, m_state, m_tick, m_clear);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        hold_ss = 0;
        hold_clr = 0;
        m_state = 2'd0;
        m_presc = 0;
        m_tick = 1'b0;
        m_clear = 1'b0;
        test_reset();
        test_start_tick();
        test_pause_resume();
        test_clear_rules();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
